// File: rtl/sram_db_pkg.sv
// Shared widths, types and helpers for the double-buffered SRAM controller.
package sram_db_pkg;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned ADDR_W  = 12;
   localparam int unsigned BANK_AW = ADDR_W - 1;
   localparam int unsigned CNT_W   = BANK_AW + 1;

   typedef logic               bank_idx_t;
   typedef logic [BANK_AW-1:0] bank_off_t;
   typedef logic [CNT_W-1:0]   tile_cnt_t;

   // Port-0 write payload presented to the SRAM macro wrapper
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } sram_wr_t;

   // Configured tile length to word count; 0 stands for a full 2048-word bank
   function automatic tile_cnt_t tile_len_decode(input bank_off_t cfg);
      tile_cnt_t len;
      len = {1'b0, cfg};
      if (cfg == '0) begin
         len = {1'b1, bank_off_t'(0)};
      end
      return len;
   endfunction

endpackage : sram_db_pkg

// File: rtl/sram_db_wr_seq.sv
// Write sequencer: per-tile word counter, tile-length latch and tile-complete pulse.
module sram_db_wr_seq
   import sram_db_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  bank_off_t cfg_tile_len,
   input  logic      wr_accept,
   output bank_off_t wr_off,
   output logic      tile_done_c
);

   tile_cnt_t cnt_q, cnt_d;
   tile_cnt_t len_q, len_d;
   tile_cnt_t len_eff;

   // The first word of a tile uses the live config; later words use the latch
   always_comb begin
      len_eff     = (cnt_q == '0) ? tile_len_decode(cfg_tile_len) : len_q;
      cnt_d       = cnt_q;
      len_d       = len_q;
      tile_done_c = 1'b0;
      if (wr_accept) begin
         if (cnt_q == '0) begin
            len_d = len_eff;
         end
         if (cnt_q == len_eff - tile_cnt_t'(1)) begin
            tile_done_c = 1'b1;
            cnt_d       = '0;
         end else begin
            cnt_d = cnt_q + tile_cnt_t'(1);
         end
      end
   end

   // Counter and length registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         len_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         len_q <= len_d;
      end
   end

   // Counter never exceeds 2047, so the low bits are the full bank offset
   assign wr_off = cnt_q[BANK_AW-1:0];

endmodule : sram_db_wr_seq

// File: rtl/sram_db_ctrl.sv
// Ping-pong controller for a 4096x32 SRAM split into two 2048-word banks:
// the producer fills one bank through port 0 while the consumer reads the
// other through port 1; ownership flips when each side finishes its bank.
module sram_db_ctrl
   import sram_db_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  bank_off_t         cfg_tile_len,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_req_valid,
   output logic              rd_req_ready,
   input  bank_off_t         rd_req_addr,
   input  logic              rd_done,
   output logic              rd_data_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic [1:0]        bank_full,
   output logic              sram_csb0,
   output logic              sram_web0,
   output logic [ADDR_W-1:0] sram_addr0,
   output logic [DATA_W-1:0] sram_din0,
   output logic              sram_csb1,
   output logic [ADDR_W-1:0] sram_addr1,
   input  logic [DATA_W-1:0] sram_dout1
);

   bank_idx_t  wr_bank_q, wr_bank_d;
   bank_idx_t  rd_bank_q, rd_bank_d;
   logic [1:0] full_q, full_d;
   logic       rd_valid_q, rd_valid_d;

   logic       wr_accept;
   logic       rd_accept;
   logic       release_c;
   logic       tile_done_c;
   bank_off_t  wr_off;
   sram_wr_t   wr_pl;

   // Handshakes: fill bank writable while empty, drain bank readable while full
   assign wr_ready     = ~full_q[wr_bank_q];
   assign wr_accept    = wr_valid & wr_ready;
   assign rd_req_ready = full_q[rd_bank_q];
   assign rd_accept    = rd_req_valid & rd_req_ready;
   assign release_c    = rd_done & full_q[rd_bank_q];

   sram_db_wr_seq u_wr_seq (
      .clk          (clk),
      .rst          (rst),
      .cfg_tile_len (cfg_tile_len),
      .wr_accept    (wr_accept),
      .wr_off       (wr_off),
      .tile_done_c  (tile_done_c)
   );

   // Bank flag and ownership update; set and clear never hit the same bank
   always_comb begin
      full_d     = full_q;
      wr_bank_d  = wr_bank_q;
      rd_bank_d  = rd_bank_q;
      rd_valid_d = rd_accept;
      if (release_c) begin
         full_d[rd_bank_q] = 1'b0;
         rd_bank_d         = ~rd_bank_q;
      end
      if (tile_done_c) begin
         full_d[wr_bank_q] = 1'b1;
         wr_bank_d         = ~wr_bank_q;
      end
   end

   // Controller state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_bank_q  <= 1'b0;
         rd_bank_q  <= 1'b0;
         full_q     <= 2'b00;
         rd_valid_q <= 1'b0;
      end else begin
         wr_bank_q  <= wr_bank_d;
         rd_bank_q  <= rd_bank_d;
         full_q     <= full_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   // Port 0: address/data always track the fill pointer; csb/web gate the write
   assign wr_pl.addr = {wr_bank_q, wr_off};
   assign wr_pl.data = wr_data;
   assign sram_csb0  = ~wr_accept;
   assign sram_web0  = ~wr_accept;
   assign sram_addr0 = wr_pl.addr;
   assign sram_din0  = wr_pl.data;

   // Port 1: read the drain bank; data returns from the macro one cycle later
   assign sram_csb1     = ~rd_accept;
   assign sram_addr1    = {rd_bank_q, rd_req_addr};
   assign rd_data_valid = rd_valid_q;
   assign rd_data       = sram_dout1;
   assign bank_full     = full_q;

endmodule : sram_db_ctrl
